// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared PRBS-8 definitions for the generator and checker
// Holds the register width, the tap mask for x^8+x^6+x^5+x^4+1 and the sync state
// encoding. The generator imports the same package, so the two ends cannot drift apart.
package lfsr_checker_pkg;

    localparam int LFSR_W = 8;

    // Taps at bits 7,5,4,3.
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - serial bit stream in, sync/error status out
// Signals:
//   bit_in, bit_valid   serial data bit, qualified by bit_valid
//   clear_err           synchronous clear of err_count
//   locked              1 while in LOCKED
//   bit_err             one-cycle pulse per LOCKED-state mismatch
//   err_count           saturating LOCKED-state error count
//   sync_state          0=SEED 1=VERIFY 2=LOCKED
// master drives the stream, slave is the checker.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_err;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       sync_state;

    modport master (
        output bit_in, bit_valid, clear_err,
        input  locked, bit_err, err_count, sync_state
    );

    modport slave (
        input  bit_in, bit_valid, clear_err,
        output locked, bit_err, err_count, sync_state
    );
endinterface

// File: rtl/lfsr_predict.sv
// rtl/lfsr_predict.sv - combinational next-bit prediction of a Fibonacci LFSR
// Ports:
//   sr_i    current shift register contents
//   pred_o  XOR of the tapped bits (next bit the generator will emit)
module lfsr_predict
    import lfsr_checker_pkg::*;
#(
    parameter int          W    = LFSR_W,
    parameter logic [W-1:0] TAPS = TAP_MASK
) (
    input  logic [W-1:0] sr_i,
    output logic         pred_o
);

    assign pred_o = ^(sr_i & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS-8 receive checker with error counting
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    lfsr_checker_if.slave: bit_in/bit_valid/clear_err in,
//          locked/bit_err/err_count/sync_state out (all registered)
// Loads 8 received bits as a seed, verifies LOCK_COUNT consecutive predictions, then
// free-runs its own LFSR and counts mismatches; LOSS_COUNT consecutive misses re-seed.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_checker_if.slave      bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  LOSS_V    = MISS_W'(LOSS_COUNT);
    localparam logic [3:0]         FILL_LAST = 4'(LFSR_W - 1);

    sync_state_e         state_q, state_d;
    logic [LFSR_W-1:0]   sr_q, sr_d;
    logic [3:0]          fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                bit_err_q, bit_err_d;
    logic                pred;

    lfsr_predict #(
        .W    (LFSR_W),
        .TAPS (TAP_MASK)
    ) u_predict (
        .sr_i   (sr_q),
        .pred_o (pred)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SEED;
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_q     <= '0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            bit_err_q <= bit_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = err_q;
        bit_err_d = 1'b0;

        if (bus.bit_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    sr_d = {sr_q[LFSR_W-2:0], bus.bit_in};
                    if (fill_q == FILL_LAST) begin
                        fill_d = '0;
                        // An all-zero seed is the LFSR lockup state; refill instead.
                        if (sr_d != '0) begin
                            state_d = ST_VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end

                ST_VERIFY: begin
                    sr_d = {sr_q[LFSR_W-2:0], bus.bit_in};
                    if (bus.bit_in == pred) begin
                        match_d = match_q + 1'b1;
                        if (match_d == LOCK_V) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        fill_d  = '0;
                        state_d = ST_SEED;
                    end
                end

                ST_LOCKED: begin
                    // Self-sustaining: received errors must not corrupt the reference.
                    sr_d = {sr_q[LFSR_W-2:0], pred};
                    if (bus.bit_in != pred) begin
                        bit_err_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        miss_d = miss_q + 1'b1;
                        if (miss_d == LOSS_V) begin
                            state_d = ST_SEED;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end

                default: state_d = ST_SEED;
            endcase
        end

        // Clear takes priority over a same-edge increment.
        if (bus.clear_err) begin
            err_d = '0;
        end
    end

    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.sync_state = state_q;
    assign bus.bit_err    = bit_err_q;
    assign bus.err_count  = err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard testbench for lfsr_checker
module tb_lfsr_checker;

    // Narrow counter so saturation is reachable in a short run.
    localparam int TB_ERR_W = 8;
    localparam int ERR_MAX  = (1 << TB_ERR_W) - 1;

    localparam logic [1:0] S_SEED   = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    typedef struct {
        logic [1:0] st;
        logic       be;
        int         ec;
    } exp_t;

    logic clk;
    logic reset;

    lfsr_checker_if #(.ERR_W(TB_ERR_W)) bus ();

    lfsr_checker #(
        .LOCK_COUNT (16),
        .LOSS_COUNT (4),
        .ERR_W      (TB_ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         checks;
    int         errors;
    logic [7:0] g;
    int         exp_err;
    logic [1:0] cur_st;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so each edge's expectation is compared on the
    // following falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("locked",     int'(bus.locked),     int'(e.st == S_LOCKED));
            chk("sync_state", int'(bus.sync_state), int'(e.st));
            chk("bit_err",    int'(bus.bit_err),    int'(e.be));
            chk("err_count",  int'(bus.err_count),  e.ec);
        end
    end

    // Reference PRBS-8 generator: s <= {s[6:0], new}, output new.
    function automatic logic gen_next();
        logic nb;
        nb = g[7] ^ g[5] ^ g[4] ^ g[3];
        g  = {g[6:0], nb};
        return nb;
    endfunction

    task automatic step(input logic b, input logic v, input logic clr, input logic rst,
                        input logic [1:0] es, input logic eb);
        exp_t e;
        #1;
        bus.bit_in    = b;
        bus.bit_valid = v;
        bus.clear_err = clr;
        reset         = rst;
        @(posedge clk);
        e.st = es;
        e.be = eb;
        e.ec = exp_err;
        sb_q.push_back(e);
        cur_st = es;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, cur_st, 1'b0);
    endtask

    task automatic do_reset();
        g       = 8'h01;
        exp_err = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1, S_SEED, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, S_SEED, 1'b0);
    endtask

    // 24 clean bits from SEED: 8 to fill, 16 verified; locked after the 24th.
    task automatic clean_lock(input int max_gap);
        logic [1:0] es;
        logic       b;
        for (int k = 1; k <= 24; k++) begin
            repeat ($urandom_range(max_gap, 0)) idle();
            b  = gen_next();
            es = (k < 8) ? S_SEED : ((k < 24) ? S_VERIFY : S_LOCKED);
            step(b, 1'b1, 1'b0, 1'b0, es, 1'b0);
        end
    endtask

    task automatic locked_bit(input logic inv, input logic clr, input logic [1:0] es);
        logic b;
        b = gen_next();
        if (inv && exp_err < ERR_MAX) exp_err++;
        if (clr) exp_err = 0;
        step(b ^ inv, 1'b1, clr, 1'b0, es, inv);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_err       = 0;
        g             = 8'h01;
        cur_st        = S_SEED;
        reset         = 1'b1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clear_err = 1'b0;

        // 1: clean lock from reset.
        do_reset();
        clean_lock(0);

        // 2: single inverted bit while locked.
        locked_bit(1'b0, 1'b0, S_LOCKED);
        locked_bit(1'b1, 1'b0, S_LOCKED);
        locked_bit(1'b0, 1'b0, S_LOCKED);
        locked_bit(1'b0, 1'b0, S_LOCKED);

        // 3: four consecutive errors drop lock, then relock on a clean stream.
        exp_err = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, S_LOCKED, 1'b0);
        locked_bit(1'b1, 1'b0, S_LOCKED);
        locked_bit(1'b1, 1'b0, S_LOCKED);
        locked_bit(1'b1, 1'b0, S_LOCKED);
        locked_bit(1'b1, 1'b0, S_SEED);
        clean_lock(0);
        locked_bit(1'b0, 1'b0, S_LOCKED);

        // 4: all-zero seeds are rejected.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, S_SEED, 1'b0);
        clean_lock(0);

        // 5: idle gaps do not move the lock point; clear wins over same-edge error.
        do_reset();
        clean_lock(5);
        idle();
        locked_bit(1'b1, 1'b0, S_LOCKED);
        idle();
        locked_bit(1'b0, 1'b0, S_LOCKED);
        locked_bit(1'b1, 1'b1, S_LOCKED);
        idle();
        locked_bit(1'b0, 1'b0, S_LOCKED);

        // 6: saturation, then reset while locked.
        do_reset();
        clean_lock(0);
        for (int i = 0; i < 90; i++) begin
            locked_bit(1'b1, 1'b0, S_LOCKED);
            locked_bit(1'b1, 1'b0, S_LOCKED);
            locked_bit(1'b1, 1'b0, S_LOCKED);
            locked_bit(1'b0, 1'b0, S_LOCKED);
        end
        exp_err = 0;
        step(gen_next() ^ 1'b1, 1'b1, 1'b0, 1'b1, S_SEED, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, S_SEED, 1'b0);

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
